mem_wb_writeback: RTL and testbench

- Write side of the register-file interface that the decode stage reads. Holds the MEM/WB pipeline register and selects the writeback source.
- Extracts and extends load data, suppresses writes to x0, and drives RegWrite_WB, RD_WB and ALU_DATA_WB into the register file in the decode stage.
- Handles pipeline stall and flush, and flags misaligned loads.

---
 rtl/rv_pkg.sv | 18 +
 rtl/load_extract.sv | 46 ++++
 rtl/mem_wb_writeback.sv | 138 +++++++++++++
 tb/tb_mem_wb_writeback.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared writeback-select and load funct3 encodings
package rv_pkg;

  localparam int DEF_XLEN = 32;

  // writeback source select
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  // load size/sign encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - load byte/half/word extraction with misalignment flag
module load_extract
  import rv_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = word[{off, 3'b000} +: 8];
  assign half_v = word[{off[1], 4'b0000} +: 16];

  // size/sign selection; unlisted encodings behave as a full word
  always_comb begin
    data       = word;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH: begin
        data       = {{(XLEN-16){half_v[15]}}, half_v};
        misaligned = off[0];
      end
      F3_LHU: begin
        data       = {{(XLEN-16){1'b0}}, half_v};
        misaligned = off[0];
      end
      F3_LW: begin
        data       = word;
        misaligned = (off != 2'b00);
      end
      default: begin
        data       = word;
        misaligned = (off != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_writeback.sv
// rtl/mem_wb_writeback.sv - MEM/WB register and writeback mux; optional MEM_WB_RETIRE_CNT_EN retire counter
module mem_wb_writeback
  import rv_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
`ifdef MEM_WB_RETIRE_CNT_EN
  , parameter int CNT_W = 64
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            VALID_MEM,
  input  logic            STALL_WB,
  input  logic            FLUSH_WB,
  input  logic            RegWrite_MEM,
  input  logic [1:0]      WB_SEL_MEM,
  input  logic [XLEN-1:0] ALU_RESULT_MEM,
  input  logic [XLEN-1:0] LOAD_WORD_MEM,
  input  logic [XLEN-1:0] PC_MEM,
  input  logic [2:0]      FUNCT3_MEM,
  input  logic [4:0]      RD_MEM,
  output logic            RegWrite_WB,
  output logic [4:0]      RD_WB,
  output logic [XLEN-1:0] ALU_DATA_WB,
  output logic            VALID_WB,
  output logic            MISALIGNED_WB
`ifdef MEM_WB_RETIRE_CNT_EN
  , output logic [CNT_W-1:0] RETIRED_WB
`endif
);

  logic            valid_q, valid_d;
  logic            regwrite_q, regwrite_d;
  logic [1:0]      wb_sel_q, wb_sel_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic [XLEN-1:0] word_q, word_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [4:0]      rd_q, rd_d;

  logic [XLEN-1:0] load_data;
  logic            load_misaligned;

  // next-state of the pipeline register: flush beats stall beats capture
  always_comb begin
    valid_d    = valid_q;
    regwrite_d = regwrite_q;
    wb_sel_d   = wb_sel_q;
    alu_d      = alu_q;
    word_d     = word_q;
    pc_d       = pc_q;
    funct3_d   = funct3_q;
    rd_d       = rd_q;
    if (FLUSH_WB) begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      wb_sel_d   = '0;
      alu_d      = '0;
      word_d     = '0;
      pc_d       = '0;
      funct3_d   = '0;
      rd_d       = '0;
    end else if (!STALL_WB) begin
      valid_d    = VALID_MEM;
      regwrite_d = RegWrite_MEM;
      wb_sel_d   = WB_SEL_MEM;
      alu_d      = ALU_RESULT_MEM;
      word_d     = LOAD_WORD_MEM;
      pc_d       = PC_MEM;
      funct3_d   = FUNCT3_MEM;
      rd_d       = RD_MEM;
    end
  end

  // pipeline register with synchronous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      wb_sel_q   <= '0;
      alu_q      <= '0;
      word_q     <= '0;
      pc_q       <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
    end else begin
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      wb_sel_q   <= wb_sel_d;
      alu_q      <= alu_d;
      word_q     <= word_d;
      pc_q       <= pc_d;
      funct3_q   <= funct3_d;
      rd_q       <= rd_d;
    end
  end

  load_extract #(.XLEN(XLEN)) u_load_extract (
    .word       (word_q),
    .off        (alu_q[1:0]),
    .funct3     (funct3_q),
    .data       (load_data),
    .misaligned (load_misaligned)
  );

  // writeback mux and write qualification, purely from registered state
  always_comb begin
    case (wb_sel_q)
      WB_LOAD: ALU_DATA_WB = load_data;
      WB_PC4:  ALU_DATA_WB = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
      default: ALU_DATA_WB = alu_q;
    endcase
    MISALIGNED_WB = valid_q & (wb_sel_q == WB_LOAD) & load_misaligned;
    RegWrite_WB   = valid_q & regwrite_q & (rd_q != 5'd0) & ~MISALIGNED_WB;
    RD_WB         = rd_q;
    VALID_WB      = valid_q;
  end

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_q, retired_d;

  // an instruction retires when it leaves WB (not held) and was not a faulting load
  always_comb begin
    retired_d = retired_q;
    if (valid_q && !MISALIGNED_WB && (FLUSH_WB || !STALL_WB))
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // retire counter, wraps naturally
  always_ff @(posedge clk) begin
    if (!rst_n) retired_q <= '0;
    else        retired_q <= retired_d;
  end

  assign RETIRED_WB = retired_q;
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb/tb_mem_wb_writeback.sv - self-checking bench for mem_wb_writeback
module tb_mem_wb_writeback;

  localparam int TB_CNT_W = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        VALID_MEM, STALL_WB, FLUSH_WB, RegWrite_MEM;
  logic [1:0]  WB_SEL_MEM;
  logic [31:0] ALU_RESULT_MEM, LOAD_WORD_MEM, PC_MEM;
  logic [2:0]  FUNCT3_MEM;
  logic [4:0]  RD_MEM;
  logic        RegWrite_WB, VALID_WB, MISALIGNED_WB;
  logic [4:0]  RD_WB;
  logic [31:0] ALU_DATA_WB;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [TB_CNT_W-1:0] RETIRED_WB;
  logic [TB_CNT_W-1:0] m_cnt;
`endif

  always #5 clk = ~clk;

  mem_wb_writeback #(
    .XLEN(32)
`ifdef MEM_WB_RETIRE_CNT_EN
    , .CNT_W(TB_CNT_W)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .VALID_MEM(VALID_MEM), .STALL_WB(STALL_WB),
    .FLUSH_WB(FLUSH_WB), .RegWrite_MEM(RegWrite_MEM), .WB_SEL_MEM(WB_SEL_MEM),
    .ALU_RESULT_MEM(ALU_RESULT_MEM), .LOAD_WORD_MEM(LOAD_WORD_MEM), .PC_MEM(PC_MEM),
    .FUNCT3_MEM(FUNCT3_MEM), .RD_MEM(RD_MEM), .RegWrite_WB(RegWrite_WB), .RD_WB(RD_WB),
    .ALU_DATA_WB(ALU_DATA_WB), .VALID_WB(VALID_WB), .MISALIGNED_WB(MISALIGNED_WB)
`ifdef MEM_WB_RETIRE_CNT_EN
    , .RETIRED_WB(RETIRED_WB)
`endif
  );

  typedef struct packed {
    logic        v;
    logic        rw;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] word;
    logic [31:0] pc;
    logic [2:0]  f3;
    logic [4:0]  rd;
  } mem_t;

  typedef struct packed {
    mem_t        in;
    logic        e_valid;
    logic        e_we;
    logic        e_mis;
    logic [31:0] e_data;
    logic        chk_data;
  } vec_t;

  mem_t held;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // misalignment rule stated directly in terms of offset and access size
  function automatic logic model_mis(mem_t m);
    int off;
    int size;
    off  = int'(m.alu[1:0]);
    size = (m.f3 == 3'd0 || m.f3 == 3'd4) ? 1 : (m.f3 == 3'd1 || m.f3 == 3'd5) ? 2 : 4;
    return m.v && (m.sel == 2'b01) && ((off % size) != 0);
  endfunction

  function automatic logic [31:0] model_data(mem_t m);
    int          off;
    logic [31:0] b, h;
    off = int'(m.alu[1:0]);
    if (m.sel == 2'b10) return m.pc + 32'd4;
    if (m.sel != 2'b01) return m.alu;
    b = (m.word >> (8 * off)) & 32'hFF;
    h = (m.word >> (16 * (off / 2))) & 32'hFFFF;
    case (m.f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'd5:    return h;
      default: return m.word;
    endcase
  endfunction

  task automatic drive(input mem_t m);
    VALID_MEM = m.v; RegWrite_MEM = m.rw; WB_SEL_MEM = m.sel;
    ALU_RESULT_MEM = m.alu; LOAD_WORD_MEM = m.word; PC_MEM = m.pc;
    FUNCT3_MEM = m.f3; RD_MEM = m.rd;
  endtask

  // one clock: advance the model with the inputs seen at the edge, then compare
  task automatic cycle();
    logic mis;
    @(posedge clk);
`ifdef MEM_WB_RETIRE_CNT_EN
    if (!rst_n) m_cnt = '0;
    else if (held.v && !model_mis(held) && (FLUSH_WB || !STALL_WB)) m_cnt = m_cnt + 1'b1;
`endif
    if (!rst_n || FLUSH_WB) held = '0;
    else if (!STALL_WB) held = {VALID_MEM, RegWrite_MEM, WB_SEL_MEM, ALU_RESULT_MEM,
                                LOAD_WORD_MEM, PC_MEM, FUNCT3_MEM, RD_MEM};
    #1;
    mis = model_mis(held);
    chk("m_valid", VALID_WB, held.v);
    chk("m_rd", RD_WB, held.rd);
    chk("m_mis", MISALIGNED_WB, mis);
    chk("m_we", RegWrite_WB, held.v && held.rw && held.rd != 0 && !mis);
    if (!mis) chk("m_data", ALU_DATA_WB, model_data(held));
`ifdef MEM_WB_RETIRE_CNT_EN
    chk("m_cnt", RETIRED_WB, m_cnt);
`endif
  endtask

  function automatic mem_t mk(logic v, logic rw, logic [1:0] sel, logic [31:0] alu,
                              logic [31:0] word, logic [31:0] pc, logic [2:0] f3, logic [4:0] rd);
    return {v, rw, sel, alu, word, pc, f3, rd};
  endfunction

  localparam logic [31:0] LW_V = 32'h80FF7F01;

  vec_t vecs[16];
  mem_t a;

  initial begin
    vecs[0]  = {mk(1,1,2'b00,32'h12345678,0,0,3'd0,5'd3), 1'b1,1'b1,1'b0,32'h12345678,1'b1};
    vecs[1]  = {mk(1,1,2'b00,32'h12345678,0,0,3'd0,5'd0), 1'b1,1'b0,1'b0,32'h12345678,1'b1};
    vecs[2]  = {mk(1,1,2'b01,32'h3,LW_V,0,3'd0,5'd4),     1'b1,1'b1,1'b0,32'hFFFFFF80,1'b1};
    vecs[3]  = {mk(1,1,2'b01,32'h1,LW_V,0,3'd4,5'd4),     1'b1,1'b1,1'b0,32'h0000007F,1'b1};
    vecs[4]  = {mk(1,1,2'b01,32'h2,LW_V,0,3'd1,5'd4),     1'b1,1'b1,1'b0,32'hFFFF80FF,1'b1};
    vecs[5]  = {mk(1,1,2'b01,32'h0,LW_V,0,3'd5,5'd4),     1'b1,1'b1,1'b0,32'h00007F01,1'b1};
    vecs[6]  = {mk(1,1,2'b01,32'h0,LW_V,0,3'd2,5'd4),     1'b1,1'b1,1'b0,32'h80FF7F01,1'b1};
    vecs[7]  = {mk(1,1,2'b01,32'h2,LW_V,0,3'd2,5'd4),     1'b1,1'b0,1'b1,32'h0,1'b0};
    vecs[8]  = {mk(1,1,2'b01,32'h1,LW_V,0,3'd1,5'd4),     1'b1,1'b0,1'b1,32'h0,1'b0};
    vecs[9]  = {mk(1,1,2'b10,32'h0,0,32'hFFFFFFFC,3'd0,5'd1), 1'b1,1'b1,1'b0,32'h0,1'b1};
    vecs[10] = {mk(1,1,2'b10,32'h0,0,32'h00000100,3'd0,5'd1), 1'b1,1'b1,1'b0,32'h104,1'b1};
    vecs[11] = {mk(1,1,2'b11,32'hCAFEF00D,0,32'h40,3'd0,5'd9), 1'b1,1'b1,1'b0,32'hCAFEF00D,1'b1};
    vecs[12] = {mk(0,1,2'b01,32'h2,LW_V,0,3'd2,5'd4),     1'b0,1'b0,1'b0,32'h80FF7F01,1'b1};
    vecs[13] = {mk(1,0,2'b00,32'h55,0,0,3'd0,5'd8),       1'b1,1'b0,1'b0,32'h55,1'b1};
    vecs[14] = {mk(1,1,2'b01,32'h2,LW_V,0,3'd0,5'd31),    1'b1,1'b1,1'b0,32'hFFFFFFFF,1'b1};
    vecs[15] = {mk(1,1,2'b01,32'h3,LW_V,0,3'd6,5'd2),     1'b1,1'b0,1'b1,32'h0,1'b0};

    held = '0;
`ifdef MEM_WB_RETIRE_CNT_EN
    m_cnt = '0;
`endif
    STALL_WB = 0; FLUSH_WB = 0; rst_n = 0;
    drive(mk(1,1,2'b00,32'hA5,0,0,3'd0,5'd5));

    // reset holds everything at zero despite a live instruction on the inputs
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("rst_we", RegWrite_WB, 0);
      chk("rst_rd", RD_WB, 0);
      chk("rst_data", ALU_DATA_WB, 0);
      chk("rst_valid", VALID_WB, 0);
      chk("rst_mis", MISALIGNED_WB, 0);
    end
    rst_n = 1;
    cycle();
    chk("post_rst_we", RegWrite_WB, 1);
    chk("post_rst_rd", RD_WB, 5);
    chk("post_rst_data", ALU_DATA_WB, 32'hA5);

    // table of single-cycle vectors
    foreach (vecs[i]) begin
      drive(vecs[i].in);
      cycle();
      chk($sformatf("vec%0d_valid", i), VALID_WB, vecs[i].e_valid);
      chk($sformatf("vec%0d_we", i), RegWrite_WB, vecs[i].e_we);
      chk($sformatf("vec%0d_mis", i), MISALIGNED_WB, vecs[i].e_mis);
      if (vecs[i].chk_data) chk($sformatf("vec%0d_data", i), ALU_DATA_WB, vecs[i].e_data);
    end

    // stall for three cycles while MEM inputs keep changing
    drive(mk(1,1,2'b00,32'hDEAD0001,0,0,3'd0,5'd7));
    cycle();
    STALL_WB = 1;
    for (int i = 0; i < 3; i++) begin
      drive(mk(1,1,2'b10,$urandom,$urandom,$urandom,3'd1,5'(i + 10)));
      cycle();
      chk("stall_we", RegWrite_WB, 1);
      chk("stall_rd", RD_WB, 7);
      chk("stall_data", ALU_DATA_WB, 32'hDEAD0001);
    end
    STALL_WB = 0;
    drive(mk(1,1,2'b00,32'h77,0,0,3'd0,5'd12));
    cycle();
    chk("unstall_rd", RD_WB, 12);

    // flush wins over stall
    STALL_WB = 1; FLUSH_WB = 1;
    cycle();
    chk("flush_valid", VALID_WB, 0);
    chk("flush_we", RegWrite_WB, 0);
    STALL_WB = 0; FLUSH_WB = 0;

    // reset asserted while stalled still clears the register
    drive(mk(1,1,2'b00,32'h99,0,0,3'd0,5'd6));
    cycle();
    STALL_WB = 1; rst_n = 0;
    cycle();
    chk("rst_stall_valid", VALID_WB, 0);
    chk("rst_stall_rd", RD_WB, 0);
    rst_n = 1; STALL_WB = 0;

`ifdef MEM_WB_RETIRE_CNT_EN
    // five instructions with two stall cycles in between, then drain
    rst_n = 0; cycle(); rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      drive(mk(1,1,2'b00,32'(i),0,0,3'd0,5'd1));
      STALL_WB = 0;
      cycle();
      if (i == 1 || i == 3) begin STALL_WB = 1; cycle(); STALL_WB = 0; end
    end
    drive(mk(0,0,2'b00,0,0,0,3'd0,5'd0));
    cycle();
    chk("retire5", RETIRED_WB, 5);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      a = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 2'($urandom),
             $urandom, $urandom, ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom,
             3'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom));
      drive(a);
      STALL_WB = ($urandom_range(0, 5) == 0);
      FLUSH_WB = ($urandom_range(0, 9) == 0);
      rst_n    = ($urandom_range(0, 49) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
